// File: rtl/layered_objects_mux.sv
// layered_objects_mux
//   Priority mux for a stack of RGB332 object layers on top of a background,
//   followed by colour expansion to OUT_W bits per channel, plus a per-layer
//   collision detector against layer 0 with per-frame capture.
//
// Ports
//   clk, resetN                 clock, asynchronous active-low reset
//   layerRGB[NUM_LAYERS*8]      RGB332 per layer, layer i in bits [8i+7:8i]
//   layerDrawingRequest[N]      per-layer "pixel drawn here"
//   layerEnable[N]              per-layer enable mask (applies same cycle)
//   backGroundRGB[8]            RGB332 colour used when no layer wins
//   blank                       high outside the active video area
//   startOfFrame                one-cycle pulse at frame start
//   redOut/greenOut/blueOut     expanded colour, 2-clock latency
//   drawingLayer                winning layer index (NUM_LAYERS = background)
//   collisionLive               sticky collisions in the current frame
//   collisionFrame              collisions captured at the last frame start
//   collisionIrq                one-cycle pulse when a captured vector is nonzero
module layered_objects_mux #(
  parameter int          NUM_LAYERS  = 4,
  parameter int          OUT_W       = 8,
  parameter logic [7:0]  TRANSPARENT = 8'hFF,
  localparam int         IW          = $clog2(NUM_LAYERS + 1)
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [NUM_LAYERS*8-1:0] layerRGB,
  input  logic [NUM_LAYERS-1:0]   layerDrawingRequest,
  input  logic [NUM_LAYERS-1:0]   layerEnable,
  input  logic [7:0]              backGroundRGB,
  input  logic                    blank,
  input  logic                    startOfFrame,
  output logic [OUT_W-1:0]        redOut,
  output logic [OUT_W-1:0]        greenOut,
  output logic [OUT_W-1:0]        blueOut,
  output logic [IW-1:0]           drawingLayer,
  output logic [NUM_LAYERS-1:0]   collisionLive,
  output logic [NUM_LAYERS-1:0]   collisionFrame,
  output logic                    collisionIrq
);

  // MSB-align the n source bits, then replicate the source LSB downward.
  // When OUT_W < n the loop simply stops early, dropping source LSBs.
  function automatic logic [OUT_W-1:0] expand(input logic [2:0] src, input int n);
    logic [OUT_W-1:0] r;
    int               j;
    r = '0;
    for (int k = 0; k < OUT_W; k++) begin
      if (k < n) j = n - 1 - k;
      else       j = 0;
      r[OUT_W-1-k] = src[j[1:0]];
    end
    return r;
  endfunction

  logic [NUM_LAYERS-1:0] eff;
  logic [NUM_LAYERS-1:0] hit;
  logic [NUM_LAYERS-2:0] hit_hi;
  logic [7:0]            sel_rgb;
  logic [IW-1:0]         sel_idx;

  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++)
      eff[i] = layerDrawingRequest[i] & layerEnable[i] &
               (layerRGB[8*i +: 8] != TRANSPARENT);
  end

  // Walk from the top index down so the lowest drawing index wins.
  always_comb begin
    sel_rgb = backGroundRGB;
    sel_idx = IW'(NUM_LAYERS);
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eff[i]) begin
        sel_rgb = layerRGB[8*i +: 8];
        sel_idx = IW'(i);
      end
    end
  end

  // Layer 0 is the reference object; bit 0 flags "layer 0 hit anything".
  assign hit_hi = eff[NUM_LAYERS-1:1] & {(NUM_LAYERS-1){eff[0] & ~blank}};
  assign hit    = {hit_hi, |hit_hi};

  // Stage 1: selection
  logic [7:0]    rgb1_q;
  logic [IW-1:0] idx1_q;
  logic          blank1_q;

  // Stage 2: expanded colour
  logic [OUT_W-1:0] red_q, green_q, blue_q;
  logic [IW-1:0]    idx2_q;

  // The index registers reset to the background index so drawingLayer keeps
  // reporting "background" while reset-time contents drain out.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rgb1_q   <= '0;
      idx1_q   <= IW'(NUM_LAYERS);
      blank1_q <= 1'b0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      idx2_q   <= IW'(NUM_LAYERS);
    end else begin
      rgb1_q   <= sel_rgb;
      idx1_q   <= sel_idx;
      blank1_q <= blank;
      red_q    <= blank1_q ? '0 : expand(rgb1_q[7:5], 3);
      green_q  <= blank1_q ? '0 : expand(rgb1_q[4:2], 3);
      blue_q   <= blank1_q ? '0 : expand({1'b0, rgb1_q[1:0]}, 2);
      idx2_q   <= idx1_q;
    end
  end

  assign redOut       = red_q;
  assign greenOut     = green_q;
  assign blueOut      = blue_q;
  assign drawingLayer = idx2_q;

  // Collision tracking
  logic [NUM_LAYERS-1:0] live_q, live_d, frame_q, frame_d, cap;
  logic                  irq_q, irq_d;

  // The frame-start cycle's own hits go into the captured vector, not the
  // new frame's live vector.
  always_comb begin
    cap     = live_q | hit;
    live_d  = startOfFrame ? '0 : cap;
    frame_d = startOfFrame ? cap : frame_q;
    irq_d   = startOfFrame & (|cap);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      live_q  <= '0;
      frame_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      live_q  <= live_d;
      frame_q <= frame_d;
      irq_q   <= irq_d;
    end
  end

  assign collisionLive  = live_q;
  assign collisionFrame = frame_q;
  assign collisionIrq   = irq_q;

endmodule
